// File: rtl/msftdvip_dtcm_responder_pkg.sv
// Shared types and helpers for the DTCM responder: response record, LFSR
// constants and the CHERI tag-aware store mask/data builders.
package msftdvip_dtcm_pkg;

  typedef struct packed {
    logic valid;
    logic err;
    logic is_read;
    logic is_tsmap;
  } resp_t;

  localparam logic [7:0] LfsrSeed = 8'hA5;
  // Polynomial x^8 + x^6 + x^5 + x^4 + 1, tap n maps to state bit n-1.
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  function automatic logic [32:0] tag_wmask(input logic [3:0] be);
    return {1'b1, {8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Only a full-word store may carry a tag; anything narrower clears it.
  function automatic logic [32:0] tag_wdata(input logic [3:0] be, input logic [32:0] wdata);
    return {(be == 4'hF) & wdata[32], wdata[31:0]};
  endfunction

endpackage

// File: rtl/msftdvip_dtcm_responder_if.sv
// Core data-memory port (req/gnt/rvalid with 33-bit capability words).
interface msftdvip_dtcm_responder_if;

  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [32:0] data_wdata;
  logic [6:0]  data_wdata_intg;
  logic        data_rvalid;
  logic [32:0] data_rdata;
  logic [6:0]  data_rdata_intg;
  logic        data_err;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata, data_wdata_intg,
    input  data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata, data_wdata_intg,
    output data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err
  );

endinterface

// File: rtl/msftdvip_dtcm_responder_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to inject grant stalls.
module msftdvip_lfsr8
  import msftdvip_dtcm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next state: shift left, XOR of tapped bits enters at bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LfsrTaps)};
  end

  // State register, reloads the seed on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/msftdvip_dtcm_responder.sv
// DTCM responder: arbitrates TS-map reads against core data accesses onto a
// single-port 33-bit SRAM, applies tag-write rules and flags window misses.
module msftdvip_dtcm_responder
  import msftdvip_dtcm_pkg::*;
#(
  parameter logic [31:0] AddrBase = 32'h200f_0000,
  parameter int unsigned MemWords = 16384,
  parameter bit          StallEn  = 1'b0,
  localparam int unsigned AW      = $clog2(MemWords)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  msftdvip_dtcm_responder_if.slave data_bus_io,
  input  logic                     tsmap_cs_i,
  input  logic [15:0]              tsmap_addr_i,
  output logic [31:0]              tsmap_rdata_o,
  output logic                     sram_cs_o,
  output logic                     sram_we_o,
  output logic [AW-1:0]            sram_addr_o,
  output logic [32:0]              sram_wdata_o,
  output logic [32:0]              sram_wmask_o,
  input  logic [32:0]              sram_rdata_i
);

  // Window bounds at 33 bits so a window touching 4 GiB cannot wrap.
  localparam logic [32:0] WinLo   = {1'b0, AddrBase};
  localparam logic [32:0] WinSize = 33'(MemWords) << 2;
  localparam logic [32:0] WinHi   = WinLo + WinSize;

  logic [7:0]  lfsr_state_s;
  logic        stall_s;
  logic        gnt_s;
  logic        in_range_s;
  logic [32:0] addr_ext_s;
  logic [32:0] offset_s;
  resp_t       resp_d;
  resp_t       resp_q;
  logic [31:0] tsmap_hold_q;
  logic        unused_s;

  msftdvip_lfsr8 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .state_o (lfsr_state_s)
  );

  assign stall_s    = StallEn & (lfsr_state_s[1:0] == 2'b00);
  assign addr_ext_s = {1'b0, data_bus_io.data_addr};
  assign in_range_s = (addr_ext_s >= WinLo) && (addr_ext_s < WinHi);
  assign offset_s   = addr_ext_s - WinLo;
  assign gnt_s      = data_bus_io.data_req & ~tsmap_cs_i & ~stall_s & ~rst_i;

  assign data_bus_io.data_gnt = gnt_s;

  // SRAM command: TS-map first, then granted in-range data accesses.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = {AW{1'b0}};
    sram_wdata_o = 33'h0;
    sram_wmask_o = 33'h0;
    if (rst_i) begin
      sram_cs_o = 1'b0;
    end else if (tsmap_cs_i) begin
      sram_cs_o   = 1'b1;
      sram_addr_o = tsmap_addr_i[AW-1:0];
    end else if (gnt_s && in_range_s) begin
      sram_cs_o   = 1'b1;
      sram_we_o   = data_bus_io.data_we;
      sram_addr_o = offset_s[AW+1:2];
      if (data_bus_io.data_we) begin
        sram_wdata_o = tag_wdata(data_bus_io.data_be, data_bus_io.data_wdata);
        sram_wmask_o = tag_wmask(data_bus_io.data_be);
      end else begin
        sram_wdata_o = 33'h0;
      end
    end else begin
      sram_cs_o = 1'b0;
    end
  end

  // Response attributes captured at grant / TS-map select.
  always_comb begin
    resp_d          = resp_t'(4'b0000);
    resp_d.valid    = gnt_s;
    resp_d.err      = gnt_s & ~in_range_s;
    resp_d.is_read  = gnt_s & ~data_bus_io.data_we;
    resp_d.is_tsmap = tsmap_cs_i & ~rst_i;
  end

  // Response register plus the TS-map result holder.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q       <= resp_t'(4'b0000);
      tsmap_hold_q <= 32'h0;
    end else begin
      resp_q <= resp_d;
      if (resp_q.is_tsmap) begin
        tsmap_hold_q <= sram_rdata_i[31:0];
      end else begin
        tsmap_hold_q <= tsmap_hold_q;
      end
    end
  end

  // SRAM data is only valid in the cycle after the select, so it is muxed live.
  assign tsmap_rdata_o = resp_q.is_tsmap ? sram_rdata_i[31:0] : tsmap_hold_q;

  assign data_bus_io.data_rvalid     = resp_q.valid;
  assign data_bus_io.data_err        = resp_q.err;
  assign data_bus_io.data_rdata      = (resp_q.valid && resp_q.is_read && !resp_q.err)
                                       ? sram_rdata_i : 33'h0;
  assign data_bus_io.data_rdata_intg = 7'h0;

  assign unused_s = ^{data_bus_io.data_wdata_intg, tsmap_addr_i[15:AW],
                      offset_s[32:AW+2], offset_s[1:0], lfsr_state_s[7:2]};

endmodule

// File: tb/tb_msftdvip_dtcm_responder.sv
// Directed and randomized checks of the DTCM responder against a word-level
// memory model, one instance without and one with grant stalls.
module tb_msftdvip_dtcm_responder;

  localparam logic [31:0] Base  = 32'h200f_0000;
  localparam int          Words = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic rst0 = 1'b1, rst1 = 1'b1;
  msftdvip_dtcm_responder_if bus0 ();
  msftdvip_dtcm_responder_if bus1 ();
  logic ts_cs0 = 1'b0, ts_cs1 = 1'b0;
  logic [15:0] ts_addr0 = 16'h0, ts_addr1 = 16'h0;
  logic [31:0] ts_rd0, ts_rd1;
  logic s_cs0, s_we0, s_cs1, s_we1;
  logic [13:0] s_addr0, s_addr1;
  logic [32:0] s_wd0, s_wm0, s_wd1, s_wm1;
  logic [32:0] s_rd0 = 33'h0, s_rd1 = 33'h0;
  logic [32:0] sram0 [Words] = '{default: 33'h0};
  logic [32:0] sram1 [Words] = '{default: 33'h0};
  logic [32:0] ref0 [Words] = '{default: 33'h0};
  logic [32:0] ref1 [Words] = '{default: 33'h0};
  logic [7:0] lfsr_m = 8'hA5;

  msftdvip_dtcm_responder #(.AddrBase(Base), .MemWords(Words), .StallEn(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst0), .data_bus_io(bus0),
    .tsmap_cs_i(ts_cs0), .tsmap_addr_i(ts_addr0), .tsmap_rdata_o(ts_rd0),
    .sram_cs_o(s_cs0), .sram_we_o(s_we0), .sram_addr_o(s_addr0),
    .sram_wdata_o(s_wd0), .sram_wmask_o(s_wm0), .sram_rdata_i(s_rd0));

  msftdvip_dtcm_responder #(.AddrBase(Base), .MemWords(Words), .StallEn(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .data_bus_io(bus1),
    .tsmap_cs_i(ts_cs1), .tsmap_addr_i(ts_addr1), .tsmap_rdata_o(ts_rd1),
    .sram_cs_o(s_cs1), .sram_we_o(s_we1), .sram_addr_o(s_addr1),
    .sram_wdata_o(s_wd1), .sram_wmask_o(s_wm1), .sram_rdata_i(s_rd1));

  // Behavioural SRAM macros with bit-masked writes and 1-cycle read latency.
  always @(posedge clk) begin
    if (s_cs0) begin
      if (s_we0) sram0[s_addr0] <= (sram0[s_addr0] & ~s_wm0) | (s_wd0 & s_wm0);
      else       s_rd0 <= sram0[s_addr0];
    end
    if (s_cs1) begin
      if (s_we1) sram1[s_addr1] <= (sram1[s_addr1] & ~s_wm1) | (s_wd1 & s_wm1);
      else       s_rd1 <= sram1[s_addr1];
    end
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    int taps [4] = '{8, 6, 5, 4};
    logic fb;
    fb = 1'b0;
    foreach (taps[t]) fb = fb ^ s[taps[t] - 1];
    return {s[6:0], fb};
  endfunction

  // Expected stall-source state for the StallEn instance.
  always @(posedge clk) lfsr_m <= rst1 ? 8'hA5 : lfsr_step(lfsr_m);

  function automatic bit in_win(input logic [31:0] a);
    longint unsigned x, lo;
    x  = 64'(a);
    lo = 64'(Base);
    return (x >= lo) && (x < lo + 64'(4 * Words));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((64'(a) - 64'(Base)) >> 2);
  endfunction

  function automatic logic [32:0] merge(input logic [32:0] old, input logic [3:0] be,
                                        input logic [32:0] wd);
    logic [32:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    r[32] = (be == 4'hF) ? wd[32] : 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0(input string tag);
    tick();
    check({tag, ".idle_rvalid"}, 64'(bus0.data_rvalid), 64'(1'b0));
  endtask

  task automatic xact0(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [32:0] wd);
    bit ok;
    int w;
    logic [32:0] exp_rd;
    ok = in_win(addr);
    w  = ok ? word_of(addr) : 0;
    bus0.data_req = 1'b1; bus0.data_we = we; bus0.data_be = be;
    bus0.data_addr = addr; bus0.data_wdata = wd;
    #1;
    check({tag, ".gnt"}, 64'(bus0.data_gnt), 64'(1'b1));
    check({tag, ".sram_cs"}, 64'(s_cs0), 64'(ok));
    exp_rd = 33'h0;
    if (ok && !we) exp_rd = ref0[w];
    if (ok && we) ref0[w] = merge(ref0[w], be, wd);
    tick();
    bus0.data_req = 1'b0;
    check({tag, ".rvalid"}, 64'(bus0.data_rvalid), 64'(1'b1));
    check({tag, ".err"}, 64'(bus0.data_err), 64'(!ok));
    check({tag, ".rdata"}, 64'(bus0.data_rdata), 64'(exp_rd));
  endtask

  bit pend1 = 1'b0;
  logic exp_err1;
  logic [32:0] exp_rd1;

  task automatic tick1();
    tick();
    check("rnd.rvalid", 64'(bus1.data_rvalid), 64'(pend1));
    if (pend1) begin
      check("rnd.err", 64'(bus1.data_err), 64'(exp_err1));
      check("rnd.rdata", 64'(bus1.data_rdata), 64'(exp_rd1));
    end
    pend1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pool [8] = '{0, 1, 2, 3, 100, 8191, 16382, 16383};
    bus0.data_req = 1'b0; bus0.data_we = 1'b0; bus0.data_be = 4'h0;
    bus0.data_addr = 32'h0; bus0.data_wdata = 33'h0; bus0.data_wdata_intg = 7'h0;
    bus1.data_req = 1'b0; bus1.data_we = 1'b0; bus1.data_be = 4'h0;
    bus1.data_addr = 32'h0; bus1.data_wdata = 33'h0; bus1.data_wdata_intg = 7'h0;

    // Reset with a write held: no grant and no SRAM select.
    tick();
    bus0.data_req = 1'b1; bus0.data_we = 1'b1; bus0.data_be = 4'hF;
    bus0.data_addr = 32'h200f_0020; bus0.data_wdata = 33'h1_1111_1111;
    #1;
    check("rst.gnt", 64'(bus0.data_gnt), 64'(1'b0));
    check("rst.sram_cs", 64'(s_cs0), 64'(1'b0));
    repeat (3) tick();
    rst0 = 1'b0; rst1 = 1'b0; bus0.data_req = 1'b0;
    #1;
    check("rst.rvalid", 64'(bus0.data_rvalid), 64'(1'b0));
    check("rst.err", 64'(bus0.data_err), 64'(1'b0));
    check("rst.rdata", 64'(bus0.data_rdata), 64'(33'h0));
    check("rst.tsmap_rdata", 64'(ts_rd0), 64'(32'h0));
    check("rst.gnt_idle", 64'(bus0.data_gnt), 64'(1'b0));
    check("rst.intg", 64'(bus0.data_rdata_intg), 64'(7'h0));

    // Full write then read-back, then a partial store clearing the tag.
    xact0("full_wr", 1'b1, 4'hF, 32'h200f_0010, 33'h1_DEAD_BEEF);
    idle0("full_wr");
    xact0("full_rd", 1'b0, 4'hF, 32'h200f_0010, 33'h0);
    check("full_rd.const", 64'(ref0[4]), 64'(33'h1_DEAD_BEEF));
    idle0("full_rd");
    xact0("part_wr", 1'b1, 4'h3, 32'h200f_0010, 33'h1_0000_1234);
    xact0("part_rd", 1'b0, 4'hF, 32'h200f_0010, 33'h0);
    check("part_rd.const", 64'(ref0[4]), 64'(33'h0_DEAD_1234));
    xact0("be0_pre", 1'b1, 4'hF, 32'h200f_0014, 33'h1_5555_AAAA);
    xact0("be0_wr", 1'b1, 4'h0, 32'h200f_0014, 33'h1_FFFF_FFFF);
    xact0("be0_rd", 1'b0, 4'hF, 32'h200f_0014, 33'h0);
    xact0("rst_wr_rd", 1'b0, 4'hF, 32'h200f_0020, 33'h0);
    idle0("rst_wr_rd");

    // Window edges.
    xact0("oor_hi_rd", 1'b0, 4'hF, 32'h2010_0000, 33'h0);
    xact0("oor_lo_wr", 1'b1, 4'hF, 32'h200e_fffc, 33'h1_2345_6789);
    xact0("last_wr", 1'b1, 4'hF, 32'h200f_fffc, 33'h1_0BAD_F00D);
    xact0("last_rd", 1'b0, 4'hF, 32'h200f_fffc, 33'h0);
    xact0("first_rd", 1'b0, 4'hF, 32'h200f_0000, 33'h0);
    idle0("edges");

    // TS-map and data read in the same cycle.
    xact0("ts_pre", 1'b1, 4'hF, 32'h200f_fe10, 33'h0_CAFE_F00D);
    ts_cs0 = 1'b1; ts_addr0 = 16'hFF84;
    bus0.data_req = 1'b1; bus0.data_we = 1'b0; bus0.data_addr = 32'h200f_0010;
    #1;
    check("coll.gnt0", 64'(bus0.data_gnt), 64'(1'b0));
    check("coll.sram_cs", 64'(s_cs0), 64'(1'b1));
    check("coll.sram_we", 64'(s_we0), 64'(1'b0));
    check("coll.sram_addr", 64'(s_addr0), 64'(14'h3F84));
    tick();
    ts_cs0 = 1'b0;
    check("coll.tsmap_rdata", 64'(ts_rd0), 64'(ref0[16'h3F84][31:0]));
    check("coll.rvalid0", 64'(bus0.data_rvalid), 64'(1'b0));
    #1;
    check("coll.gnt1", 64'(bus0.data_gnt), 64'(1'b1));
    tick();
    bus0.data_req = 1'b0;
    check("coll.rvalid1", 64'(bus0.data_rvalid), 64'(1'b1));
    check("coll.rdata", 64'(bus0.data_rdata), 64'(ref0[4]));
    idle0("coll");
    check("coll.tsmap_hold", 64'(ts_rd0), 64'(32'hCAFE_F00D));

    // Back-to-back reads of distinct words.
    for (int i = 0; i < 4; i++)
      xact0("b2b_wr", 1'b1, 4'hF, 32'h200f_0100 + 32'(4 * i), {1'(i), 32'hA000_0000 + 32'(i)});
    for (int i = 0; i < 4; i++)
      xact0("b2b_rd", 1'b0, 4'hF, 32'h200f_0100 + 32'(4 * i), 33'h0);
    idle0("b2b");

    // Randomized traffic on the stalling instance.
    for (int i = 0; i < 1000; i++) begin
      int sel;
      bit granted, exp_g, ok;
      int w;
      logic [31:0] addr;
      if (i == 500) begin
        bus1.data_req = 1'b1; bus1.data_we = 1'b1; bus1.data_be = 4'hF;
        bus1.data_addr = Base + 32'(4 * 3); bus1.data_wdata = 33'h1_7777_7777;
        granted = 1'b0;
        for (int c = 0; c < 32 && !granted; c++) begin
          #1;
          exp_g = (lfsr_m[1:0] != 2'b00);
          check("mrst.gnt", 64'(bus1.data_gnt), 64'(exp_g));
          if (exp_g) begin
            granted = 1'b1;
            check("mrst.cs_pre", 64'(s_cs1), 64'(1'b1));
            rst1 = 1'b1;
            #1;
            check("mrst.gnt_rst", 64'(bus1.data_gnt), 64'(1'b0));
            check("mrst.cs_rst", 64'(s_cs1), 64'(1'b0));
          end
          tick1();
        end
        check("mrst.timeout", 64'(granted), 64'(1'b1));
        tick1();
        rst1 = 1'b0; bus1.data_req = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus1.data_req = 1'b0;
        #1;
        check("rnd.gnt_idle", 64'(bus1.data_gnt), 64'(1'b0));
        tick1();
      end
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       addr = Base + 32'(4 * pool[$urandom_range(0, 7)]);
      else if (sel == 7) addr = 32'h200e_fffc;
      else if (sel == 8) addr = 32'h2010_0000;
      else               addr = $urandom & 32'hFFFF_FFFC;
      bus1.data_req = 1'b1; bus1.data_we = 1'($urandom_range(0, 1));
      bus1.data_be = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      bus1.data_addr = addr; bus1.data_wdata = {1'($urandom), 32'($urandom)};
      granted = 1'b0;
      for (int c = 0; c < 32 && !granted; c++) begin
        #1;
        exp_g = (lfsr_m[1:0] != 2'b00);
        check("rnd.gnt", 64'(bus1.data_gnt), 64'(exp_g));
        if (exp_g) begin
          granted = 1'b1;
          ok = in_win(addr);
          w = ok ? word_of(addr) : 0;
          pend1 = 1'b1;
          exp_err1 = !ok;
          exp_rd1 = (ok && !bus1.data_we) ? ref1[w] : 33'h0;
          if (ok && bus1.data_we) ref1[w] = merge(ref1[w], bus1.data_be, bus1.data_wdata);
        end
        tick1();
      end
      check("rnd.timeout", 64'(granted), 64'(1'b1));
      bus1.data_req = 1'b0;
    end
    #1;
    tick1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
